// File: rtl/csum_pkg.sv
// Shared helpers for the streaming ones-complement checksum engine.
// fold  : 32-bit partial sum -> 16-bit end-around-carry sum (two folds).
// bswap : swap the two bytes of a 16-bit word.
package csum_pkg;
  localparam int CSUM_W = 16;
  localparam int LEN_W  = 16;

  // Two folds are always enough for a 32-bit input: after the first
  // the value is at most 0x1FFFE, and 0xFFFE + 1 cannot carry again.
  function automatic logic [CSUM_W-1:0] fold(input logic [31:0] x);
    logic [16:0] s;
    s = {1'b0, x[15:0]} + {1'b0, x[31:16]};
    s = {1'b0, s[15:0]} + {16'h0, s[16]};
    return s[15:0];
  endfunction

  function automatic logic [CSUM_W-1:0] bswap(input logic [CSUM_W-1:0] x);
    return {x[7:0], x[15:8]};
  endfunction
endpackage

// File: rtl/csum_res_fifo.sv
// Synchronous result FIFO with occupancy count.
// push/din  : write side (ignored when full unless a pop happens in the same cycle)
// pop/dout  : read side, dout shows the head entry (0 when empty)
// count     : number of stored entries
module csum_res_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign dout    = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/csum_stream_engine.sv
// Streaming RFC 1071 checksum engine with per-frame start offset and seed.
// in_*   : valid/ready beat stream; in_start/in_seed sampled on a frame's first beat
// csum_* : valid/ready result stream, complemented checksum plus summed byte count
// Pipeline: S1 mask+reduce, S2 accumulate, S3 finalise, then the result FIFO.
module csum_stream_engine
  import csum_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int REVERSE    = 1,
  parameter int RES_DEPTH  = 4,
  parameter int ZERO_SUB   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [KEEP_WIDTH-1:0] in_keep,
  input  logic [15:0]           in_start,
  input  logic [15:0]           in_seed,
  output logic                  csum_valid,
  input  logic                  csum_ready,
  output logic [15:0]           csum_out,
  output logic [15:0]           csum_len
);
  localparam int NW    = KEEP_WIDTH/2;
  localparam int CW    = $clog2(KEEP_WIDTH+1);
  localparam int FCW   = $clog2(RES_DEPTH+1);

  // ---- input side: frame tracking, mask and reduction ----
  logic                  in_fire, first_q;
  logic [15:0]           fb_q, start_q, cur_fb, cur_start;
  logic [16:0]           fb_sum;
  logic [KEEP_WIDTH-1:0] incl;
  logic [DATA_WIDTH-1:0] mdata;
  logic [31:0]           partial;
  logic [CW-1:0]         cnt;

  always_comb begin
    cur_fb    = first_q ? '0 : fb_q;
    cur_start = first_q ? in_start : start_q;
    fb_sum    = {1'b0, cur_fb} + 17'(KEEP_WIDTH);
    incl      = '0;
    mdata     = '0;
    cnt       = '0;
    partial   = '0;
    // 17-bit compare so a saturated fb still includes every later byte
    for (int j = 0; j < KEEP_WIDTH; j++) begin
      incl[j] = in_keep[j] && (({1'b0, cur_fb} + 17'(j)) >= {1'b0, cur_start});
      if (incl[j]) mdata[8*j +: 8] = in_data[8*j +: 8];
      cnt = cnt + CW'(incl[j]);
    end
    // Even lanes are even frame bytes since KEEP_WIDTH is even
    for (int w = 0; w < NW; w++) begin
      if (REVERSE != 0) partial = partial + {16'h0, mdata[16*w +: 8], mdata[16*w+8 +: 8]};
      else              partial = partial + {16'h0, mdata[16*w +: 16]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= 1'b1;
      fb_q    <= '0;
      start_q <= '0;
    end else if (in_fire) begin
      first_q <= in_last;
      fb_q    <= in_last ? '0 : (fb_sum[16] ? 16'hFFFF : fb_sum[15:0]);
      start_q <= cur_start;
    end
  end

  // ---- S1 ----
  logic          s1_vld, s1_last, s1_first, s1_odd;
  logic [15:0]   s1_seed;
  logic [31:0]   s1_sum;
  logic [CW-1:0] s1_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0; s1_last <= 1'b0; s1_first <= 1'b0; s1_odd <= 1'b0;
      s1_seed <= '0; s1_sum <= '0; s1_cnt <= '0;
    end else begin
      s1_vld   <= in_fire;
      s1_last  <= in_last;
      s1_first <= first_q;
      s1_odd   <= cur_start[0];
      s1_seed  <= in_seed;
      s1_sum   <= partial;
      s1_cnt   <= cnt;
    end
  end

  // ---- S2: accumulate ----
  // For an odd start the seed enters pre-swapped; the final swap then
  // restores it, leaving seed + swap(data sum).
  logic              s2_fin, odd_q;
  logic [CSUM_W-1:0] acc_q, base;
  logic [LEN_W-1:0]  len_q, len_base;
  logic [16:0]       len_sum;

  always_comb begin
    base     = s1_first ? (s1_odd ? bswap(s1_seed) : s1_seed) : acc_q;
    len_base = s1_first ? '0 : len_q;
    len_sum  = {1'b0, len_base} + 17'(s1_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_fin <= 1'b0; odd_q <= 1'b0; acc_q <= '0; len_q <= '0;
    end else begin
      s2_fin <= s1_vld && s1_last;
      if (s1_vld) begin
        acc_q <= fold({16'h0, base} + s1_sum);
        len_q <= len_sum[16] ? 16'hFFFF : len_sum[15:0];
        if (s1_first) odd_q <= s1_odd;
      end
    end
  end

  // ---- S3: finalise ----
  logic              s3_vld;
  logic [31:0]       s3_data;
  logic [CSUM_W-1:0] res;

  always_comb begin
    res = ~(odd_q ? bswap(acc_q) : acc_q);
    if ((ZERO_SUB != 0) && (res == '0)) res = 16'hFFFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_vld  <= 1'b0;
      s3_data <= '0;
    end else begin
      s3_vld  <= s2_fin;
      s3_data <= {res, len_q};
    end
  end

  // ---- result FIFO and flow control ----
  logic [FCW-1:0] fifo_count;
  logic [31:0]    fifo_dout;
  logic [2:0]     in_flight;
  logic           fifo_pop;

  // Reserve a FIFO slot for every frame end still in the pipeline
  assign in_flight = 3'(s1_vld && s1_last) + 3'(s2_fin) + 3'(s3_vld);
  assign in_ready  = !rst && ((32'(fifo_count) + 32'(in_flight)) < 32'(RES_DEPTH));
  assign in_fire   = in_valid && in_ready;

  assign csum_valid = (fifo_count != '0);
  assign fifo_pop   = csum_valid && csum_ready;
  assign csum_out   = fifo_dout[31:16];
  assign csum_len   = fifo_dout[15:0];

  csum_res_fifo #(.WIDTH(32), .DEPTH(RES_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s3_vld),
    .din   (s3_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_csum_stream_engine.sv
module tb_csum_stream_engine;
  logic         clk, rst, in_valid, in_last, csum_ready;
  logic [255:0] in_data;
  logic [31:0]  in_keep;
  logic [15:0]  in_start, in_seed;
  logic         in_ready, csum_valid, in_ready_z, csum_valid_z;
  logic [15:0]  csum_out, csum_len, csum_out_z, csum_len_z;

  int total, bad, timeouts;

  csum_stream_engine #(.DATA_WIDTH(256), .REVERSE(1), .RES_DEPTH(2), .ZERO_SUB(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_data(in_data), .in_keep(in_keep), .in_start(in_start), .in_seed(in_seed),
    .csum_valid(csum_valid), .csum_ready(csum_ready), .csum_out(csum_out), .csum_len(csum_len));

  csum_stream_engine #(.DATA_WIDTH(256), .REVERSE(1), .RES_DEPTH(2), .ZERO_SUB(1)) dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_z), .in_last(in_last),
    .in_data(in_data), .in_keep(in_keep), .in_start(in_start), .in_seed(in_seed),
    .csum_valid(csum_valid_z), .csum_ready(csum_ready), .csum_out(csum_out_z), .csum_len(csum_len_z));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Called and returns at a negedge; beat is accepted on the posedge in between.
  task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l,
                           input logic [15:0] st, input logic [15:0] sd);
    int n;
    in_valid = 1'b1; in_data = d; in_keep = k; in_last = l; in_start = st; in_seed = sd;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) timeouts++;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic get_result(output logic ok, output logic [15:0] c, output logic [15:0] l,
                            output logic [15:0] cz);
    int n;
    n = 0;
    while (!csum_valid && n < 50) begin @(negedge clk); n++; end
    ok = csum_valid; c = csum_out; l = csum_len; cz = csum_out_z;
    if (ok) begin
      csum_ready = 1'b1;
      @(negedge clk);
      csum_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (csum_valid !== 1'b0) begin bad++; $display("FAIL reset_csum_valid got=%b want=0", csum_valid); end
    total++; if (csum_out !== 16'h0) begin bad++; $display("FAIL reset_csum_out got=%h want=0000", csum_out); end
    total++; if (csum_len !== 16'h0) begin bad++; $display("FAIL reset_csum_len got=%h want=0000", csum_len); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_ipv4();
    logic [7:0]   hdr [20];
    logic [255:0] d1, d2;
    logic ok; logic [15:0] c, l, cz;
    hdr = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
            8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};
    d1 = '0; d2 = '0;
    for (int i = 0; i < 14; i++) d1[8*i +: 8] = 8'h11;
    for (int i = 0; i < 18; i++) d1[8*(14+i) +: 8] = hdr[i];
    d2[7:0] = hdr[18]; d2[15:8] = hdr[19];
    send_beat(d1, 32'hFFFF_FFFF, 1'b0, 16'd14, 16'h0);
    send_beat(d2, 32'h0000_0003, 1'b1, 16'd14, 16'h0);
    for (int i = 0; i < 3; i++) begin
      total++; if (csum_valid !== 1'b0) begin bad++; $display("FAIL ipv4_latency_early cyc=%0d got=%b want=0", i, csum_valid); end
      @(negedge clk);
    end
    total++; if (csum_valid !== 1'b1) begin bad++; $display("FAIL ipv4_latency_due got=%b want=1", csum_valid); end
    get_result(ok, c, l, cz);
    total++; if (!ok || c !== 16'hB861) begin bad++; $display("FAIL ipv4_csum got=%h want=b861", c); end
    total++; if (!ok || l !== 16'd20) begin bad++; $display("FAIL ipv4_len got=%0d want=20", l); end
  endtask

  task automatic test_odd_offset();
    logic [255:0] d; logic ok; logic [15:0] c, l, cz;
    d = '0; d[7:0] = 8'hAA; d[15:8] = 8'h01; d[23:16] = 8'h02;
    send_beat(d, 32'h7, 1'b1, 16'd1, 16'h0);
    get_result(ok, c, l, cz);
    total++; if (!ok || c !== 16'hFEFD) begin bad++; $display("FAIL odd_csum got=%h want=fefd", c); end
    total++; if (!ok || l !== 16'd2) begin bad++; $display("FAIL odd_len got=%0d want=2", l); end
  endtask

  task automatic test_zero_sub();
    logic [255:0] d; logic ok; logic [15:0] c, l, cz;
    d = '0; d[15:0] = 16'hFFFF;
    send_beat(d, 32'h3, 1'b1, 16'd0, 16'h0);
    get_result(ok, c, l, cz);
    total++; if (!ok || c !== 16'h0000) begin bad++; $display("FAIL zero_nosub got=%h want=0000", c); end
    total++; if (!ok || cz !== 16'hFFFF) begin bad++; $display("FAIL zero_sub got=%h want=ffff", cz); end
    total++; if (!ok || l !== 16'd2) begin bad++; $display("FAIL zero_len got=%0d want=2", l); end
  endtask

  task automatic test_seed_wrap();
    logic [255:0] d; logic ok; logic [15:0] c, l, cz;
    d = '0; d[7:0] = 8'h00; d[15:8] = 8'h01;
    send_beat(d, 32'h3, 1'b1, 16'd0, 16'hFFFF);
    get_result(ok, c, l, cz);
    total++; if (!ok || c !== 16'hFFFE) begin bad++; $display("FAIL seed_wrap_csum got=%h want=fffe", c); end
    total++; if (!ok || l !== 16'd2) begin bad++; $display("FAIL seed_wrap_len got=%0d want=2", l); end
  endtask

  task automatic test_start_past_end();
    logic [255:0] d; logic ok; logic [15:0] c, l, cz;
    d = '0; d[15:0] = 16'hBBAA;
    send_beat(d, 32'h3, 1'b1, 16'd100, 16'h1234);
    get_result(ok, c, l, cz);
    total++; if (!ok || c !== 16'hEDCB) begin bad++; $display("FAIL past_end_csum got=%h want=edcb", c); end
    total++; if (!ok || l !== 16'd0) begin bad++; $display("FAIL past_end_len got=%0d want=0", l); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] d; logic ok; logic [15:0] c, l, cz;
    d = '0; d[7:0] = 8'h01; d[15:8] = 8'h02;
    send_beat(d, 32'h3, 1'b0, 16'd0, 16'h0);
    d = '0; d[7:0] = 8'h03; d[15:8] = 8'h04;
    send_beat(d, 32'h3, 1'b1, 16'd0, 16'h0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_no_bubble got=%b want=1", in_ready); end
    d = '0; d[7:0] = 8'h99; d[15:8] = 8'h99; d[23:16] = 8'h77; d[31:24] = 8'h05;
    send_beat(d, 32'hF, 1'b1, 16'd3, 16'h0010);
    get_result(ok, c, l, cz);
    total++; if (!ok || c !== 16'hFBF9 || l !== 16'd4) begin bad++; $display("FAIL b2b_frame1 got=%h/%0d want=fbf9/4", c, l); end
    get_result(ok, c, l, cz);
    total++; if (!ok || c !== 16'hFAEF) begin bad++; $display("FAIL b2b_frame2_csum got=%h want=faef", c); end
    total++; if (!ok || l !== 16'd1) begin bad++; $display("FAIL b2b_frame2_len got=%0d want=1", l); end
  endtask

  task automatic test_backpressure();
    logic [255:0] d; logic ok; logic [15:0] c, l, cz;
    d = '0; d[15:0] = 16'h3412;
    send_beat(d, 32'h3, 1'b1, 16'd0, 16'h0);
    d = '0; d[15:0] = 16'h0F0F;
    send_beat(d, 32'h3, 1'b1, 16'd0, 16'h0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_after_second got=%b want=0", in_ready); end
    repeat (5) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b want=0", in_ready); end
    total++; if (csum_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_full got=%b want=1", csum_valid); end
    get_result(ok, c, l, cz);
    total++; if (!ok || c !== 16'hEDCB) begin bad++; $display("FAIL bp_first got=%h want=edcb", c); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_pop got=%b want=1", in_ready); end
    d = '0; d[15:0] = 16'h0100;
    send_beat(d, 32'h3, 1'b1, 16'd0, 16'h0002);
    get_result(ok, c, l, cz);
    total++; if (!ok || c !== 16'hF0F0) begin bad++; $display("FAIL bp_second got=%h want=f0f0", c); end
    get_result(ok, c, l, cz);
    total++; if (!ok || c !== 16'hFFFC || l !== 16'd2) begin bad++; $display("FAIL bp_third got=%h/%0d want=fffc/2", c, l); end
  endtask

  task automatic test_reset_mid_frame();
    logic [255:0] d; logic ok; logic [15:0] c, l, cz;
    d = '0; d[15:0] = 16'h1111;
    send_beat(d, 32'h3, 1'b0, 16'd0, 16'h0);
    send_beat(d, 32'h3, 1'b0, 16'd0, 16'h0);
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b want=0", in_ready); end
    @(negedge clk);
    total++; if (csum_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid_during got=%b want=0", csum_valid); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (csum_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid_after got=%b want=0", csum_valid); end
    d = '0; d[7:0] = 8'h55; d[15:8] = 8'h66; d[23:16] = 8'hAB; d[31:24] = 8'hCD;
    send_beat(d, 32'hF, 1'b1, 16'd2, 16'h0);
    get_result(ok, c, l, cz);
    total++; if (!ok || c !== 16'h5432 || l !== 16'd2) begin bad++; $display("FAIL mid_rst_fresh got=%h/%0d want=5432/2", c, l); end
    repeat (6) @(negedge clk);
    total++; if (csum_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_stale got=%b want=0", csum_valid); end
  endtask

  initial begin
    total = 0; bad = 0; timeouts = 0;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_keep = '0;
    in_start = '0; in_seed = '0; csum_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_ipv4();
    test_odd_offset();
    test_zero_sub();
    test_seed_wrap();
    test_start_past_end();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    total++; if (timeouts != 0) begin bad++; $display("FAIL in_ready_timeouts got=%0d want=0", timeouts); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
